// File: rtl/riscv32ima_wback.sv
// riscv32ima_wback: write-back arbiter (ALU > round-robin LSU/MDU) and RAW scoreboard
// Single writer of the GPRF write port; decode stalls on rsX_busy.
module riscv32ima_wback #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int REG_DATA_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      nrst,
  input  logic                      issue_valid,
  input  logic [REG_ADDR_WIDTH-1:0] issue_rd,
  input  logic [REG_ADDR_WIDTH-1:0] rs0_addr,
  input  logic [REG_ADDR_WIDTH-1:0] rs1_addr,
  output logic                      rs0_busy,
  output logic                      rs1_busy,
  input  logic                      alu_valid,
  input  logic [REG_ADDR_WIDTH-1:0] alu_rd,
  input  logic [REG_DATA_WIDTH-1:0] alu_data,
  input  logic                      lsu_valid,
  output logic                      lsu_ready,
  input  logic [REG_ADDR_WIDTH-1:0] lsu_rd,
  input  logic [REG_DATA_WIDTH-1:0] lsu_data,
  input  logic                      mdu_valid,
  output logic                      mdu_ready,
  input  logic [REG_ADDR_WIDTH-1:0] mdu_rd,
  input  logic [REG_DATA_WIDTH-1:0] mdu_data,
  output logic                      wback_reg_wen,
  output logic [REG_ADDR_WIDTH-1:0] wback_reg_addr,
  output logic [REG_DATA_WIDTH-1:0] wback_reg_data,
  output logic [31:0]               wback_count
);
  localparam int NREG = 1 << REG_ADDR_WIDTH;
  logic [NREG-1:0]           pend_q, pend_d;
  logic                      last_q, last_d;
  logic                      wen_q, wen_d, acc;
  logic [REG_ADDR_WIDTH-1:0] addr_q, win_rd;
  logic [REG_DATA_WIDTH-1:0] data_q, win_data;
  logic [31:0]               cnt_q;
  // last_q=1 means MDU won last, so LSU takes the next contended cycle
  assign lsu_ready = !alu_valid && lsu_valid && (!mdu_valid || last_q);
  assign mdu_ready = !alu_valid && mdu_valid && (!lsu_valid || !last_q);
  assign acc       = alu_valid || lsu_ready || mdu_ready;
  assign win_rd    = alu_valid ? alu_rd : lsu_ready ? lsu_rd : mdu_rd;
  assign win_data  = alu_valid ? alu_data : lsu_ready ? lsu_data : mdu_data;
  assign wen_d     = acc && (win_rd != '0);
  assign last_d    = lsu_ready ? 1'b0 : mdu_ready ? 1'b1 : last_q;
  // Clear before set: a newer issue to the same rd still owes a result
  always_comb begin
    pend_d = pend_q;
    if (wen_q) pend_d[addr_q] = 1'b0;
    if (issue_valid) pend_d[issue_rd] = 1'b1;
    pend_d[0] = 1'b0;
  end
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      pend_q <= '0;
      last_q <= 1'b1;
      wen_q  <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      pend_q <= pend_d;
      last_q <= last_d;
      wen_q  <= wen_d;
      cnt_q  <= cnt_q + 32'(wen_q);
      if (acc) begin
        addr_q <= win_rd;
        data_q <= win_data;
      end
    end
  end
  assign rs0_busy       = pend_q[rs0_addr];
  assign rs1_busy       = pend_q[rs1_addr];
  assign wback_reg_wen  = wen_q;
  assign wback_reg_addr = addr_q;
  assign wback_reg_data = data_q;
  assign wback_count    = cnt_q;
endmodule

// File: tb/tb_riscv32ima_wback.sv
// tb_riscv32ima_wback: directed + random checks against a transaction-level reference model.
module tb_riscv32ima_wback;
  logic        clk = 1'b0, nrst = 1'b0;
  logic        issue_valid, alu_valid, lsu_valid, mdu_valid;
  logic [4:0]  issue_rd, rs0_addr, rs1_addr, alu_rd, lsu_rd, mdu_rd;
  logic [31:0] alu_data, lsu_data, mdu_data;
  logic        rs0_busy, rs1_busy, lsu_ready, mdu_ready, wback_reg_wen;
  logic [4:0]  wback_reg_addr;
  logic [31:0] wback_reg_data, wback_count;

  riscv32ima_wback #(.REG_ADDR_WIDTH(5), .REG_DATA_WIDTH(32)) dut (
    .clk(clk), .nrst(nrst), .issue_valid(issue_valid), .issue_rd(issue_rd),
    .rs0_addr(rs0_addr), .rs1_addr(rs1_addr), .rs0_busy(rs0_busy), .rs1_busy(rs1_busy),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_rd(mdu_rd), .mdu_data(mdu_data),
    .wback_reg_wen(wback_reg_wen), .wback_reg_addr(wback_reg_addr),
    .wback_reg_data(wback_reg_data), .wback_count(wback_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;
  // Reference model: outstanding-result set, expected write port, commit count
  bit          m_pend [32];
  bit          m_wen, m_last_lsu;
  logic [4:0]  m_addr;
  logic [31:0] m_data, m_cnt, cnt_before;
  int          last_win;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    foreach (m_pend[i]) m_pend[i] = 1'b0;
    m_wen = 1'b0; m_addr = '0; m_data = '0; m_cnt = '0;
    m_last_lsu = 1'b0; last_win = 0;
  endtask

  // 0 none, 1 ALU, 2 LSU, 3 MDU
  function automatic int pick();
    if (alu_valid) return 1;
    if (lsu_valid && mdu_valid) return m_last_lsu ? 3 : 2;
    if (lsu_valid) return 2;
    if (mdu_valid) return 3;
    return 0;
  endfunction

  task automatic idle();
    alu_valid = 1'b0; lsu_valid = 1'b0; mdu_valid = 1'b0; issue_valid = 1'b0;
  endtask

  // One clock: check combinational outputs, step model at the edge, check registered outputs
  task automatic cyc();
    int win;
    logic [4:0]  wrd;
    logic [31:0] wd;
    #1;
    win = pick();
    wrd = win == 1 ? alu_rd : win == 2 ? lsu_rd : mdu_rd;
    wd  = win == 1 ? alu_data : win == 2 ? lsu_data : mdu_data;
    chk("lsu_ready", 32'(lsu_ready), 32'(win == 2));
    chk("mdu_ready", 32'(mdu_ready), 32'(win == 3));
    chk("rs0_busy", 32'(rs0_busy), 32'(m_pend[rs0_addr]));
    chk("rs1_busy", 32'(rs1_busy), 32'(m_pend[rs1_addr]));
    @(posedge clk);
    if (m_wen) begin
      m_cnt = m_cnt + 1;
      m_pend[m_addr] = 1'b0;
    end
    if (issue_valid && issue_rd != 0) m_pend[issue_rd] = 1'b1;
    m_wen = win != 0 && wrd != 0;
    if (win != 0) begin
      m_addr = wrd;
      m_data = wd;
    end
    if (win == 2) m_last_lsu = 1'b1;
    if (win == 3) m_last_lsu = 1'b0;
    last_win = win;
    #1;
    chk("wen", 32'(wback_reg_wen), 32'(m_wen));
    chk("addr", 32'(wback_reg_addr), 32'(m_addr));
    chk("data", wback_reg_data, m_data);
    chk("count", wback_count, m_cnt);
  endtask

  task automatic rand_inputs();
    alu_valid = ($urandom % 4) == 0;
    alu_rd = 5'($urandom); alu_data = $urandom;
    if (!(lsu_valid && last_win != 2)) begin
      lsu_valid = $urandom % 2; lsu_rd = 5'($urandom); lsu_data = $urandom;
    end
    if (!(mdu_valid && last_win != 3)) begin
      mdu_valid = $urandom % 2; mdu_rd = 5'($urandom); mdu_data = $urandom;
    end
    issue_valid = $urandom % 2; issue_rd = 5'($urandom);
    rs0_addr = 5'($urandom); rs1_addr = 5'($urandom);
  endtask

  initial begin
    idle();
    issue_rd = 0; rs0_addr = 0; rs1_addr = 0;
    alu_rd = 0; lsu_rd = 0; mdu_rd = 0; alu_data = 0; lsu_data = 0; mdu_data = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wen", 32'(wback_reg_wen), 0);
    chk("rst_addr", 32'(wback_reg_addr), 0);
    chk("rst_data", wback_reg_data, 0);
    chk("rst_count", wback_count, 0);
    #3 nrst = 1'b1;

    // ALU only
    alu_valid = 1'b1; alu_rd = 5; alu_data = 32'h1234_5678;
    cyc();
    chk("alu_wen", 32'(wback_reg_wen), 1);
    chk("alu_addr", 32'(wback_reg_addr), 5);
    chk("alu_data", wback_reg_data, 32'h1234_5678);
    idle();
    cyc();
    chk("alu_count", wback_count, 1);

    // Contention: ALU first, then LSU (reset favours LSU), then alternation
    alu_valid = 1'b1; alu_rd = 3; alu_data = 32'h33;
    lsu_valid = 1'b1; lsu_rd = 4; lsu_data = 32'h44;
    mdu_valid = 1'b1; mdu_rd = 6; mdu_data = 32'h66;
    #1 chk("cont_lsu_blocked", 32'(lsu_ready), 0);
    cyc();
    chk("cont_alu_addr", 32'(wback_reg_addr), 3);
    alu_valid = 1'b0;
    cyc();
    chk("cont_lsu_addr", 32'(wback_reg_addr), 4);
    lsu_rd = 8; lsu_data = 32'h88;
    cyc();
    chk("cont_mdu_addr", 32'(wback_reg_addr), 6);
    mdu_rd = 10; mdu_data = 32'hAA;
    cyc();
    chk("cont_lsu2_addr", 32'(wback_reg_addr), 8);
    lsu_valid = 1'b0;
    cyc();
    chk("cont_mdu2_addr", 32'(wback_reg_addr), 10);

    // Scoreboard set/clear timing
    idle();
    issue_valid = 1'b1; issue_rd = 7; rs0_addr = 7;
    cyc();
    issue_valid = 1'b0;
    #1 chk("sb_busy_set", 32'(rs0_busy), 1);
    mdu_valid = 1'b1; mdu_rd = 7; mdu_data = 32'h77;
    cyc();
    mdu_valid = 1'b0;
    #1 chk("sb_busy_n1", 32'(rs0_busy), 1);
    cyc();
    chk("sb_busy_n2", 32'(rs0_busy), 0);

    // Set and clear on the same index: set wins
    alu_valid = 1'b1; alu_rd = 9; alu_data = 32'h99;
    cyc();
    alu_valid = 1'b0; issue_valid = 1'b1; issue_rd = 9; rs1_addr = 9;
    cyc();
    chk("collide_wen_seen", 32'(m_pend[9]), 1);
    issue_valid = 1'b0;
    cyc();
    chk("collide_busy", 32'(rs1_busy), 1);

    // x0: never pending, never written
    issue_valid = 1'b1; issue_rd = 0; rs0_addr = 0;
    cyc();
    issue_valid = 1'b0;
    chk("x0_busy", 32'(rs0_busy), 0);
    cnt_before = m_cnt;
    lsu_valid = 1'b1; lsu_rd = 0; lsu_data = 32'hDEAD;
    #1 chk("x0_lsu_ready", 32'(lsu_ready), 1);
    cyc();
    chk("x0_wen", 32'(wback_reg_wen), 0);
    lsu_valid = 1'b0;
    cyc();
    chk("x0_count", wback_count, cnt_before);

    // Random traffic
    last_win = 0;
    for (int i = 0; i < 400; i++) begin
      rand_inputs();
      cyc();
    end

    // Asynchronous reset mid-run
    rand_inputs();
    #2 nrst = 1'b0;
    idle();
    #1;
    chk("mrst_wen", 32'(wback_reg_wen), 0);
    chk("mrst_addr", 32'(wback_reg_addr), 0);
    chk("mrst_data", wback_reg_data, 0);
    chk("mrst_count", wback_count, 0);
    for (int r = 0; r < 32; r++) begin
      rs0_addr = 5'(r);
      #1 chk("mrst_busy", 32'(rs0_busy), 0);
    end
    @(negedge clk) nrst = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
    for (int i = 0; i < 200; i++) begin
      rand_inputs();
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
